// File: rtl/brom_pkg.sv
// ---------------------------------------------------------------------------
// brom_pkg
// Shared definitions for the BROM arbiter slice: default geometry, the
// arbiter FSM state type and a helper that sizes requester index fields.
// No ports (package).
// ---------------------------------------------------------------------------
package brom_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_BROM_DEPTH = 256;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    // Width of a field able to hold a requester index 0..n-1 (at least 1 bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/brom_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Starting at i_ptr and wrapping modulo
// NUM_REQ, picks the first requester whose valid bit is set.
//
// Ports:
//   i_valid  [NUM_REQ]  request valid vector
//   i_ptr    [IDX_W]    highest-priority requester index (must be < NUM_REQ)
//   o_grant  [NUM_REQ]  one-hot grant (all zero when nothing is valid)
//   o_idx    [IDX_W]    index of the granted requester (0 when none)
//   o_any    [1]        at least one requester is valid
// ---------------------------------------------------------------------------
module rr_pick
    import brom_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int unsigned      w_j;
    logic [IDX_W-1:0] w_sel;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        w_sel   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // Candidate index (i_ptr + k) mod NUM_REQ without a divider.
            w_j = 32'(i_ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            w_sel = IDX_W'(w_j);
            if (!o_any && i_valid[w_sel]) begin
                o_any          = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

endmodule

// File: rtl/brom_arbiter.sv
// ---------------------------------------------------------------------------
// brom_arbiter
// Shares a single-port BROM between NUM_REQ requesters with round-robin
// arbitration. A request is accepted in IDLE (req_ready pulses for the
// granted requester), the BROM controls are registered for one ACCESS cycle,
// and the response (one-hot rsp_valid pulse, read data, range error) is
// registered at the end of that cycle.
//
// Ports:
//   ck          clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   [NUM_REQ]             per-requester request valid
//   req_we      [NUM_REQ]             per-requester write enable
//   req_addr    [NUM_REQ*DATA_WIDTH]  word addresses, requester i at [i*DW +: DW]
//   req_wdata   [NUM_REQ*DATA_WIDTH]  write data, same packing
//   req_ready   [NUM_REQ]             one-hot accept strobe (combinational)
//   rsp_valid   [NUM_REQ]             one-hot one-cycle response pulse
//   rsp_rdata   [DATA_WIDTH]          read data, held until the next response
//   rsp_err     [1]                   out-of-range flag, qualified by rsp_valid
//   brom_addr   [DATA_WIDTH]          BROM address (registered)
//   brom_din    [DATA_WIDTH]          BROM write data (registered)
//   brom_wen    [1]                   BROM write enable (registered)
//   brom_ce     [1]                   BROM chip enable (registered)
//   brom_dout   [DATA_WIDTH]          BROM combinational read data
// ---------------------------------------------------------------------------
module brom_arbiter
    import brom_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BROM_DEPTH = DEF_BROM_DEPTH,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                          ck,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         brom_addr,
    output logic [DATA_WIDTH-1:0]         brom_din,
    output logic                          brom_wen,
    output logic                          brom_ce,
    input  logic [DATA_WIDTH-1:0]         brom_dout
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    // Compared one bit wider so a depth equal to 2**DATA_WIDTH still works.
    localparam logic [DATA_WIDTH:0] DEPTH_LIMIT = (DATA_WIDTH+1)'(BROM_DEPTH);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    arb_state_t              r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_gnt_idx;
    logic                    r_we;
    logic                    r_range_err;
    logic [DATA_WIDTH-1:0]   r_brom_addr;
    logic [DATA_WIDTH-1:0]   r_brom_din;
    logic                    r_brom_wen;
    logic                    r_brom_ce;
    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    // Next-state values
    arb_state_t              w_state_nxt;
    logic [IDX_W-1:0]        w_rr_ptr_nxt;
    logic [IDX_W-1:0]        w_gnt_idx_nxt;
    logic                    w_we_nxt;
    logic                    w_range_err_nxt;
    logic [DATA_WIDTH-1:0]   w_brom_addr_nxt;
    logic [DATA_WIDTH-1:0]   w_brom_din_nxt;
    logic                    w_brom_wen_nxt;
    logic                    w_brom_ce_nxt;
    logic [NUM_REQ-1:0]      w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;
    logic                    w_rsp_err_nxt;

    // Arbitration results
    logic [NUM_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_any;
    logic [DATA_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_wdata;
    logic                    w_sel_we;
    logic                    w_sel_err;
    logic [NUM_REQ-1:0]      w_gnt_onehot;
    logic [IDX_W-1:0]        w_ptr_after;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_sel_addr   = req_addr [w_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_wdata  = req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_we     = req_we[w_idx];
    assign w_sel_err    = ({1'b0, w_sel_addr} >= DEPTH_LIMIT);
    assign w_gnt_onehot = NUM_REQ'(1) << r_gnt_idx;
    assign w_ptr_after  = (32'(r_gnt_idx) == NUM_REQ - 1) ? '0 : r_gnt_idx + 1'b1;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_we_nxt        = r_we;
        w_range_err_nxt = r_range_err;
        w_brom_addr_nxt = r_brom_addr;
        w_brom_din_nxt  = r_brom_din;
        w_brom_wen_nxt  = r_brom_wen;
        w_brom_ce_nxt   = r_brom_ce;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = 1'b0;
        req_ready       = '0;

        case (r_state)
            ARB_IDLE: begin
                w_brom_ce_nxt  = 1'b0;
                w_brom_wen_nxt = 1'b0;
                if (w_any) begin
                    req_ready       = w_grant;
                    w_brom_addr_nxt = w_sel_addr;
                    w_brom_din_nxt  = w_sel_wdata;
                    w_we_nxt        = w_sel_we;
                    w_range_err_nxt = w_sel_err;
                    // Out-of-range accesses never reach the BROM.
                    w_brom_ce_nxt   = ~w_sel_err;
                    w_brom_wen_nxt  = w_sel_we & ~w_sel_err;
                    w_gnt_idx_nxt   = w_idx;
                    w_state_nxt     = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                w_rsp_valid_nxt = w_gnt_onehot;
                w_rsp_rdata_nxt = (r_we || r_range_err) ? '0 : brom_dout;
                w_rsp_err_nxt   = r_range_err;
                w_brom_ce_nxt   = 1'b0;
                w_brom_wen_nxt  = 1'b0;
                w_rr_ptr_nxt    = w_ptr_after;
                w_state_nxt     = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= '0;
            r_gnt_idx   <= '0;
            r_we        <= 1'b0;
            r_range_err <= 1'b0;
            r_brom_addr <= '0;
            r_brom_din  <= '0;
            r_brom_wen  <= 1'b0;
            r_brom_ce   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_we        <= w_we_nxt;
            r_range_err <= w_range_err_nxt;
            r_brom_addr <= w_brom_addr_nxt;
            r_brom_din  <= w_brom_din_nxt;
            r_brom_wen  <= w_brom_wen_nxt;
            r_brom_ce   <= w_brom_ce_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign brom_addr = r_brom_addr;
    assign brom_din  = r_brom_din;
    assign brom_wen  = r_brom_wen;
    assign brom_ce   = r_brom_ce;

endmodule

// File: tb/tb_brom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_brom_arbiter
// Self-checking bench for brom_arbiter with a behavioural BROM attached.
// ---------------------------------------------------------------------------
module tb_brom_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int N     = 2;

    logic              ck = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_we;
    logic [N*DW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [DW-1:0]     brom_addr;
    logic [DW-1:0]     brom_din;
    logic              brom_wen;
    logic              brom_ce;
    logic [DW-1:0]     brom_dout;

    int n_vec = 0;
    int n_mis = 0;

    always #5 ck = ~ck;

    brom_arbiter #(
        .DATA_WIDTH (DW),
        .BROM_DEPTH (DEPTH),
        .NUM_REQ    (N)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .brom_addr (brom_addr),
        .brom_din  (brom_din),
        .brom_wen  (brom_wen),
        .brom_ce   (brom_ce),
        .brom_dout (brom_dout)
    );

    // Initial BROM contents; word 3 carries a recognisable marker.
    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 3) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural BROM: combinational read, write on the clock edge.
    logic [DW-1:0] mem [DEPTH];
    logic          do_init;

    always_comb brom_dout = (brom_addr < DEPTH) ? mem[brom_addr[7:0]] : 32'hBAD0_BAD0;

    always @(posedge ck) begin
        if (do_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (brom_ce && brom_wen && brom_addr < DEPTH) begin
            mem[brom_addr[7:0]] <= brom_din;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int r, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid[r]         = v;
        req_we[r]            = we;
        req_addr[r*DW +: DW]  = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    // ---------------- table of single transactions ----------------
    typedef struct {
        int          r;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_ce;
        logic        exp_wen;
    } vec_t;

    vec_t tbl[10];

    // Entered just after a negedge with the DUT in IDLE; leaves at the
    // negedge of the response cycle (DUT back in IDLE).
    task automatic do_txn(input vec_t t);
        clear_inputs();
        drive(t.r, 1'b1, t.we, t.addr, t.wdata);
        #1;
        check("tbl_ready", 64'(req_ready), 64'(1 << t.r));
        @(negedge ck);
        req_valid = '0;
        check("tbl_ce", 64'(brom_ce), 64'(t.exp_ce));
        check("tbl_wen", 64'(brom_wen), 64'(t.exp_wen));
        check("tbl_addr", 64'(brom_addr), 64'(t.addr));
        check("tbl_rsp_idle", 64'(rsp_valid), 64'(0));
        @(negedge ck);
        check("tbl_rsp_valid", 64'(rsp_valid), 64'(1 << t.r));
        check("tbl_rdata", 64'(rsp_rdata), 64'(t.exp_rdata));
        check("tbl_err", 64'(rsp_err), 64'(t.exp_err));
        check("tbl_ce_off", 64'(brom_ce), 64'(0));
    endtask

    task automatic reset_pulse();
        @(negedge ck);
        rst = 1'b1;
        do_init = 1'b1;
        clear_inputs();
        @(negedge ck);
        do_init = 1'b0;
    endtask

    // ---------------- reference model state (random phase) ----------------
    logic [31:0] ref_mem [DEPTH];
    logic        pend   [N];
    logic        p_we   [N];
    logic [31:0] p_addr [N];
    logic [31:0] p_wdat [N];

    initial begin
        automatic int exp_rdy[8] = '{1, 0, 2, 0, 1, 0, 2, 0};
        automatic int exp_rsp[8] = '{0, 0, 1, 0, 2, 0, 1, 0};
        automatic bit got0;
        automatic int r1_extra, gnt0_cyc, r1_seen;
        automatic bit m_busy, m_we, m_err, m_ce, m_wen;
        automatic int m_ptr, m_g, g;
        automatic logic [31:0] m_addr, m_wdata, m_din, m_rdata;
        automatic logic [N-1:0] m_rsp;
        automatic logic m_rerr;

        tbl[0] = '{0, 1'b0, 32'd3,         32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1, 1'b1, 32'd10,        32'h1234_5678, 32'h0,         1'b0, 1'b1, 1'b1};
        tbl[2] = '{1, 1'b0, 32'd10,        32'h0,         32'h1234_5678, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{0, 1'b0, 32'd256,       32'h0,         32'h0,         1'b1, 1'b0, 1'b0};
        tbl[4] = '{1, 1'b1, 32'd300,       32'hAAAA_5555, 32'h0,         1'b1, 1'b0, 1'b0};
        tbl[5] = '{0, 1'b0, 32'd255,       32'h0,         init_word(255), 1'b0, 1'b1, 1'b0};
        tbl[6] = '{0, 1'b1, 32'd255,       32'h0BAD_F00D, 32'h0,         1'b0, 1'b1, 1'b1};
        tbl[7] = '{1, 1'b0, 32'd255,       32'h0,         32'h0BAD_F00D, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{0, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0};
        tbl[9] = '{1, 1'b0, 32'd0,         32'h0,         init_word(0),  1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        do_init = 1'b1;
        clear_inputs();
        @(negedge ck);
        @(negedge ck);
        do_init = 1'b0;

        // Reset state
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_err", 64'(rsp_err), 64'(0));
        check("rst_ce", 64'(brom_ce), 64'(0));
        check("rst_wen", 64'(brom_wen), 64'(0));
        check("rst_addr", 64'(brom_addr), 64'(0));
        check("rst_din", 64'(brom_din), 64'(0));

        // Reset in the middle of a write access to address 5
        @(negedge ck);
        rst = 1'b0;
        drive(0, 1'b1, 1'b1, 32'd5, 32'hCAFE_F00D);
        #1;
        check("abort_ready", 64'(req_ready), 64'(1));
        @(negedge ck);
        req_valid = '0;
        check("abort_ce", 64'(brom_ce), 64'(1));
        check("abort_wen", 64'(brom_wen), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("abort_ce_off", 64'(brom_ce), 64'(0));
        check("abort_wen_off", 64'(brom_wen), 64'(0));
        check("abort_addr", 64'(brom_addr), 64'(0));
        check("abort_din", 64'(brom_din), 64'(0));
        check("abort_rsp", 64'(rsp_valid), 64'(0));
        @(negedge ck);
        check("abort_no_rsp", 64'(rsp_valid), 64'(0));
        rst = 1'b0;
        do_txn('{0, 1'b0, 32'd5, 32'h0, init_word(5), 1'b0, 1'b1, 1'b0});

        // Table of single transactions, issued back-to-back
        for (int i = 0; i < 10; i++) do_txn(tbl[i]);

        // Contention: both requesters valid from reset
        reset_pulse();
        drive(0, 1'b1, 1'b0, 32'd20, 32'h0);
        drive(1, 1'b1, 1'b0, 32'd21, 32'h0);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("cont_ready", 64'(req_ready), 64'(exp_rdy[c]));
            check("cont_rsp", 64'(rsp_valid), 64'(exp_rsp[c]));
            if (exp_rsp[c] == 1) check("cont_rdata0", 64'(rsp_rdata), 64'(init_word(20)));
            if (exp_rsp[c] == 2) check("cont_rdata1", 64'(rsp_rdata), 64'(init_word(21)));
            @(negedge ck);
        end

        // Fairness: requester 1 held, requester 0 raised once
        reset_pulse();
        drive(1, 1'b1, 1'b0, 32'd40, 32'h0);
        rst = 1'b0;
        got0 = 1'b0;
        r1_extra = 0;
        r1_seen = 0;
        gnt0_cyc = -1;
        for (int c = 0; c < 12 && !got0; c++) begin
            if (c == 1) drive(0, 1'b1, 1'b0, 32'd41, 32'h0);
            #1;
            if (req_ready[1]) begin
                if (r1_seen > 0) r1_extra++;
                r1_seen++;
            end
            if (req_ready[0]) begin
                got0 = 1'b1;
                gnt0_cyc = c;
            end
            @(negedge ck);
            if (got0) req_valid[0] = 1'b0;
        end
        check("fair_granted", 64'(got0), 64'(1));
        check("fair_r1_between", 64'(r1_extra), 64'(0));
        check("fair_cycle", 64'(gnt0_cyc), 64'(2));

        // Randomized traffic against a transaction-level reference model
        reset_pulse();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        for (int r = 0; r < N; r++) pend[r] = 1'b0;
        m_busy = 0; m_ptr = 0; m_g = 0; m_we = 0; m_err = 0;
        m_ce = 0; m_wen = 0; m_addr = '0; m_din = '0; m_wdata = '0;
        m_rdata = '0; m_rsp = '0; m_rerr = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_rsp_valid", 64'(rsp_valid), 64'(m_rsp));
            check("rnd_rsp_err", 64'(rsp_err), 64'(m_rerr));
            check("rnd_rdata", 64'(rsp_rdata), 64'(m_rdata));
            check("rnd_ce", 64'(brom_ce), 64'(m_ce));
            check("rnd_wen", 64'(brom_wen), 64'(m_wen));
            check("rnd_addr", 64'(brom_addr), 64'(m_addr));
            check("rnd_din", 64'(brom_din), 64'(m_din));

            for (int r = 0; r < N; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    automatic int sel = int'($urandom_range(0, 9));
                    pend[r]   = 1'b1;
                    p_we[r]   = 1'($urandom_range(0, 1));
                    p_wdat[r] = $urandom();
                    if (sel < 7)      p_addr[r] = $urandom_range(0, 15);
                    else if (sel < 9) p_addr[r] = $urandom_range(250, 262);
                    else              p_addr[r] = $urandom();
                end
                if (pend[r]) drive(r, 1'b1, p_we[r], p_addr[r], p_wdat[r]);
                else         drive(r, 1'b0, 1'($urandom_range(0, 1)), $urandom(), $urandom());
            end
            #1;

            g = -1;
            if (!m_busy) begin
                for (int k = 0; k < N; k++) begin
                    automatic int i = (m_ptr + k) % N;
                    if (g < 0 && pend[i]) g = i;
                end
            end
            check("rnd_ready", 64'(req_ready), (g >= 0) ? 64'(1 << g) : 64'(0));

            if (m_busy) begin
                m_rsp  = N'(1 << m_g);
                m_rerr = m_err;
                m_rdata = (m_we || m_err) ? 32'h0 : ref_mem[m_addr[7:0]];
                if (m_we && !m_err) ref_mem[m_addr[7:0]] = m_wdata;
                m_ce   = 0;
                m_wen  = 0;
                m_ptr  = (m_g + 1) % N;
                m_busy = 0;
            end else begin
                m_rsp  = '0;
                m_rerr = 1'b0;
                m_ce   = 0;
                m_wen  = 0;
                if (g >= 0) begin
                    m_busy  = 1;
                    m_g     = g;
                    m_we    = p_we[g];
                    m_addr  = p_addr[g];
                    m_wdata = p_wdat[g];
                    m_din   = p_wdat[g];
                    m_err   = (p_addr[g] >= DEPTH);
                    m_ce    = !m_err;
                    m_wen   = m_we && !m_err;
                    pend[g] = 1'b0;
                end
            end
            @(negedge ck);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
